cordic_phase_chip_slicer: RTL and testbench
===========================================

# cordic_phase_chip_slicer

Downstream neighbour of the CORDIC angle stage in the ZigBee O-QPSK/MSK receiver. It takes the per-sample phase angle produced by the CORDIC and differentiates consecutive angles with ±180° wrap handling. It slices the sign of each phase step into a chip bit and packs chips into 32-chip words for the despreader/correlator.

## Interface

Parameters:
- CHIPS_PER_WORD, default 32: chips per output word (2..32).
- ANGLE_W, default 16: angle width, signed two's complement, integer degrees.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- i_angle_valid  in  1  qualifies i_angle for one cycle; no backpressure.
- i_angle  in  ANGLE_W  signed angle, degrees.
- i_sync  in  1  realign pulse from the preamble detector; restarts chip packing.
- o_diff  out  ANGLE_W  signed wrapped phase step of the last chip, range [-179,180].
- o_chip  out  1  sliced chip bit.
- o_chip_valid  out  1  one-cycle pulse per produced chip.
- o_word  out  CHIPS_PER_WORD  packed chips, first-received chip in MSB.
- o_word_valid  out  1  one-cycle pulse when o_word is complete.
- o_chip_cnt  out  5  chips held in the current partial word (0..CHIPS_PER_WORD-1).

## Operation

- State machine: EMPTY (no reference angle held) and RUN (reference held).
  - Reset goes to EMPTY.
  - EMPTY with i_angle_valid: store the clamped angle as prev, go to RUN. No chip is produced.
  - RUN with i_angle_valid: produce a chip, store the new angle as prev, stay in RUN.
  - Any state with i_sync: go to EMPTY.
- Input clamp: i_angle > 180 is used as 180; i_angle < -180 is used as -180.
- Difference:
  - d = a - prev, computed in ANGLE_W+1 bits.
  - If d > 180, d -= 360. If d <= -180, d += 360. The result range is [-179,180].
  - o_diff = d truncated to ANGLE_W.
- Slicing:
  - chip = 1 if d > 0; chip = 0 if d < 0.
  - If d == 0, chip repeats the last produced chip. Last chip is 0 after reset or sync.
- Packing:
  - word_sr <= {word_sr[CHIPS_PER_WORD-2:0], chip}; cnt increments.
  - When cnt reaches CHIPS_PER_WORD-1 and a chip is produced:
    - o_word <= completed word, o_word_valid pulses.
    - cnt <= 0, word_sr <= 0.
- i_sync:
  - Clears prev-valid, cnt, word_sr and last chip.
  - No o_word_valid is emitted for the partial word.
  - If i_angle_valid is high in the same cycle, that sample becomes the new reference. No chip is produced and the block is in RUN the next cycle.
  - o_word keeps its last completed value.

## Timing

- Reset values: o_diff=0, o_chip=0, o_chip_valid=0, o_word=0, o_word_valid=0, o_chip_cnt=0, state EMPTY.
- Latency is 1 cycle. For a sample accepted in RUN at edge n, o_chip/o_diff/o_chip_valid are valid after edge n+1.
- o_word_valid coincides with the o_chip_valid of the word's last chip.
- Outputs o_chip, o_diff and o_word hold between pulses. Valid signals are single-cycle.
- Back-to-back i_angle_valid every cycle is supported: one chip per cycle, sustained.
- Gaps in i_angle_valid do not clear prev; differentiation continues across gaps.
- Asserting reset mid-word immediately forces all reset values. No partial output is produced.

## Test plan

- Reset, then angles 0, 10, 20, -5, -5 -> chips 1,1,0, then 0 (d==0 repeats last chip); o_diff = 10, 10, -25, 0.
- Wrap: angles 170 then -170 -> d = +20, chip 1. Angles -170 then 170 -> d = -20, chip 0. Angles 0 then 180 -> d = 180, chip 1. Angles 90 then -90 -> d = -180 wraps to 180, chip 1.
- 33 samples alternating +45° steps as 16×(up,down) pattern, back-to-back -> exactly one o_word_valid. o_word=32'hAAAAAAAA, aligned with the 33rd sample's chip; o_chip_cnt returns to 0.
- i_sync after 10 chips -> no o_word_valid. Next valid sample produces no chip. Following 32 chips produce one word; cnt counts 0..31 from the sync.
- i_sync and i_angle_valid together with angle 60, then angle 70 -> first chip 1 with o_diff=10 one cycle after the 70 sample.
- Out-of-range input 300 after 0 -> clamped to 180, d=180, chip 1. Reset asserted mid-word -> all outputs 0 in the same cycle; next valid sample produces no chip.

Source files
------------

// File: rtl/cordic_phase_chip_slicer.sv
`default_nettype none
// ============================================================================
// Module   : cordic_phase_chip_slicer
// Purpose  : Differentiates consecutive CORDIC phase angles with +/-180 degree
//            wrap handling. Each phase step is sliced on its sign into a chip
//            bit, and the chips are packed MSB-first into CHIPS_PER_WORD-chip
//            words for the despreader/correlator.
// Ports    : clock, reset           rising-edge clock, async active-high reset
//            i_angle_valid/i_angle  phase sample in integer degrees (signed)
//            i_sync                 realign pulse; restarts reference and packing
//            o_diff                 wrapped phase step of the last chip
//            o_chip/o_chip_valid    sliced chip bit and its one-cycle strobe
//            o_word/o_word_valid    completed chip word and its one-cycle strobe
//            o_chip_cnt             chips held in the current partial word
// Revision : 1.0  initial release
// ============================================================================
module cordic_phase_chip_slicer #(
  parameter int CHIPS_PER_WORD = 32,
  parameter int ANGLE_W        = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             i_angle_valid,
  input  logic signed [ANGLE_W-1:0]        i_angle,
  input  logic                             i_sync,
  output logic signed [ANGLE_W-1:0]        o_diff,
  output logic                             o_chip,
  output logic                             o_chip_valid,
  output logic        [CHIPS_PER_WORD-1:0] o_word,
  output logic                             o_word_valid,
  output logic        [4:0]                o_chip_cnt
);

  // The difference is one bit wider than the angle so a - prev cannot overflow.
  localparam int DW = ANGLE_W + 1;

  localparam logic signed [ANGLE_W-1:0] ANG_MAX  = ANGLE_W'(180);
  localparam logic signed [ANGLE_W-1:0] ANG_MIN  = ANGLE_W'(-180);
  localparam logic signed [DW-1:0]      D_P180   = DW'(180);
  localparam logic signed [DW-1:0]      D_M180   = DW'(-180);
  localparam logic signed [DW-1:0]      D_360    = DW'(360);
  localparam logic        [4:0]         LAST_CNT = 5'(CHIPS_PER_WORD - 1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,  // no reference angle held
    RUN   = 1'b1   // reference angle held in prev
  } state_t;

  state_t state;
  state_t state_next;
  logic   produce;

  logic signed [ANGLE_W-1:0]        prev;
  logic                             last_chip;
  logic        [CHIPS_PER_WORD-2:0] word_sr;
  logic        [4:0]                cnt;

  logic signed [ANGLE_W-1:0]        angle_clamped;
  logic signed [DW-1:0]             diff_raw;
  logic signed [DW-1:0]             diff_wrap;
  logic                             chip_bit;
  logic        [CHIPS_PER_WORD-1:0] word_shift;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A sync sample with valid becomes the new reference, so it lands in RUN
  // without producing a chip.
  always_comb begin
    state_next = state;
    produce    = 1'b0;
    if (i_sync) begin
      state_next = i_angle_valid ? RUN : EMPTY;
    end else if (i_angle_valid) begin
      state_next = RUN;
      produce    = (state == RUN);
    end
  end

  // --------------------------------------------------------------------------
  // Clamp, differentiate, wrap, slice
  // --------------------------------------------------------------------------
  always_comb begin
    angle_clamped = i_angle;
    if (i_angle > ANG_MAX) begin
      angle_clamped = ANG_MAX;
    end else if (i_angle < ANG_MIN) begin
      angle_clamped = ANG_MIN;
    end
  end

  assign diff_raw = {angle_clamped[ANGLE_W-1], angle_clamped} - {prev[ANGLE_W-1], prev};

  // Both operands lie in [-180,180], so one correction folds the step into
  // [-179,180].
  always_comb begin
    diff_wrap = diff_raw;
    if (diff_raw > D_P180) begin
      diff_wrap = diff_raw - D_360;
    end else if (diff_raw <= D_M180) begin
      diff_wrap = diff_raw + D_360;
    end
  end

  // A zero step carries no phase information, so the previous chip repeats.
  assign chip_bit   = (diff_wrap == '0) ? last_chip : ~diff_wrap[DW-1];
  assign word_shift = {word_sr, chip_bit};

  // --------------------------------------------------------------------------
  // Datapath registers and outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev         <= '0;
      last_chip    <= 1'b0;
      word_sr      <= '0;
      cnt          <= '0;
      o_diff       <= '0;
      o_chip       <= 1'b0;
      o_chip_valid <= 1'b0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
    end else begin
      o_chip_valid <= produce;
      o_word_valid <= 1'b0;
      if (i_sync) begin
        // Partial word is discarded; o_word keeps the last completed word.
        last_chip <= 1'b0;
        word_sr   <= '0;
        cnt       <= '0;
        if (i_angle_valid) begin
          prev <= angle_clamped;
        end
      end else if (i_angle_valid) begin
        prev <= angle_clamped;
        if (produce) begin
          o_diff    <= diff_wrap[ANGLE_W-1:0];
          o_chip    <= chip_bit;
          last_chip <= chip_bit;
          if (cnt == LAST_CNT) begin
            o_word       <= word_shift;
            o_word_valid <= 1'b1;
            word_sr      <= '0;
            cnt          <= '0;
          end else begin
            word_sr <= word_shift[CHIPS_PER_WORD-2:0];
            cnt     <= cnt + 5'd1;
          end
        end
      end
    end
  end

  assign o_chip_cnt = cnt;

endmodule
`default_nettype wire

// File: tb/tb_cordic_phase_chip_slicer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_phase_chip_slicer
// Purpose  : Self-checking bench for cordic_phase_chip_slicer. Stimulus pushes
//            expected chips/words into queues; a monitor pops and compares
//            whenever the DUT strobes an output.
// Revision : 1.0  initial release
// ============================================================================
module tb_cordic_phase_chip_slicer;

  localparam int CPW = 32;
  localparam int AW  = 16;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 angle_valid;
  logic signed [AW-1:0] angle;
  logic                 sync;
  logic signed [AW-1:0] diff;
  logic                 chip;
  logic                 chip_valid;
  logic [CPW-1:0]       word;
  logic                 word_valid;
  logic [4:0]           chip_cnt;

  cordic_phase_chip_slicer #(
    .CHIPS_PER_WORD(CPW),
    .ANGLE_W       (AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .i_angle_valid(angle_valid),
    .i_angle      (angle),
    .i_sync       (sync),
    .o_diff       (diff),
    .o_chip       (chip),
    .o_chip_valid (chip_valid),
    .o_word       (word),
    .o_word_valid (word_valid),
    .o_chip_cnt   (chip_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int d;
    bit c;
    int n;
  } chip_exp_t;

  chip_exp_t      chip_q[$];
  logic [CPW-1:0] word_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit m_have;
  int m_prev;
  bit m_last;
  bit m_bits[$];

  logic [CPW-1:0] held_word;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int a);
    if (a > 180) return 180;
    if (a < -180) return -180;
    return a;
  endfunction

  task automatic model_step(input bit v, input int ang, input bit s);
    int a;
    int d;
    bit c;
    logic [CPW-1:0] w;
    a = clamp(ang);
    if (s) begin
      m_last = 1'b0;
      m_bits.delete();
      m_have = v;
      if (v) m_prev = a;
    end else if (v) begin
      if (!m_have) begin
        m_have = 1'b1;
        m_prev = a;
      end else begin
        d = a - m_prev;
        if (d > 180) d = d - 360;
        else if (d <= -180) d = d + 360;
        if (d > 0) c = 1'b1;
        else if (d < 0) c = 1'b0;
        else c = m_last;
        m_last = c;
        m_prev = a;
        m_bits.push_back(c);
        if (m_bits.size() == CPW) begin
          w = '0;
          foreach (m_bits[i]) w = (w << 1) | CPW'(m_bits[i]);
          word_q.push_back(w);
          m_bits.delete();
        end
        chip_q.push_back('{d, c, m_bits.size()});
      end
    end
  endtask

  task automatic drive(input bit v, input int ang, input bit s);
    logic signed [AW-1:0] t;
    @(posedge clock);
    #1;
    t           = ang[AW-1:0];
    angle_valid = v;
    angle       = t;
    sync        = s;
    model_step(v, int'(t), s);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0);
  endtask

  // Outputs produced at the edge that captures the last sample are checked by
  // the monitor at the following negedge, before reset is raised.
  task automatic do_reset();
    @(posedge clock);
    #1;
    angle_valid = 1'b0;
    sync        = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("rst_diff", longint'(diff), 0);
    check("rst_chip", longint'(chip), 0);
    check("rst_chip_valid", longint'(chip_valid), 0);
    check("rst_word", longint'(word), 0);
    check("rst_word_valid", longint'(word_valid), 0);
    check("rst_chip_cnt", longint'(chip_cnt), 0);
    check("pending_before_reset", longint'(chip_q.size() + word_q.size()), 0);
    chip_q.delete();
    word_q.delete();
    m_have = 1'b0;
    m_prev = 0;
    m_last = 1'b0;
    m_bits.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Monitor
  always @(negedge clock) begin
    chip_exp_t      e;
    logic [CPW-1:0] ew;
    if (reset) begin
      held_word = '0;
    end else begin
      if (chip_valid) begin
        if (chip_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_chip: got chip_valid=1 expected no chip at %0t", $time);
        end else begin
          e = chip_q.pop_front();
          check("diff", longint'(diff), longint'(e.d));
          check("chip", longint'(chip), longint'(e.c));
          check("chip_cnt", longint'(chip_cnt), longint'(e.n));
        end
      end
      if (word_valid) begin
        check("word_with_chip", longint'(chip_valid), 1);
        if (word_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got word_valid=1 word=%0h expected none at %0t", word, $time);
        end else begin
          ew = word_q.pop_front();
          check("word", longint'(word), longint'(ew));
          held_word = ew;
        end
      end else begin
        check("word_hold", longint'(word), longint'(held_word));
      end
    end
  end

  initial begin
    int r;
    int ang;
    bit v;
    bit s;
    reset       = 1'b1;
    angle_valid = 1'b0;
    angle       = '0;
    sync        = 1'b0;
    held_word   = '0;
    do_reset();

    // Basic differentiation and zero-step repeat
    drive(1, 0, 0);
    drive(1, 10, 0);
    drive(1, 20, 0);
    drive(1, -5, 0);
    drive(1, -5, 0);

    // Wrap cases, each pair re-referenced by a sync+valid sample
    drive(1, 170, 1);  drive(1, -170, 0);
    drive(1, -170, 1); drive(1, 170, 0);
    drive(1, 0, 1);    drive(1, 180, 0);
    drive(1, 90, 1);   drive(1, -90, 0);
    idle(3);

    // 33 back-to-back samples: one full word of alternating chips
    do_reset();
    for (int k = 0; k < 33; k++) drive(1, (k % 2) ? 45 : 0, 0);
    idle(3);

    // Sync after 10 chips discards the partial word
    for (int k = 0; k < 11; k++) drive(1, k * 7, 0);
    drive(0, 0, 1);
    idle(2);
    for (int k = 0; k < 33; k++) drive(1, (k % 3) * 50 - 60, 0);
    idle(3);

    // Sync with valid, then a step of +10
    drive(1, 60, 1);
    drive(1, 70, 0);
    idle(2);

    // Out-of-range input clamps to 180
    drive(1, 0, 1);
    drive(1, 300, 0);
    drive(1, -1000, 0);
    for (int k = 0; k < 5; k++) drive(1, k * 30, 0);

    // Reset mid-word; the next sample only becomes the reference
    do_reset();
    drive(1, 40, 0);
    drive(1, 50, 0);
    idle(3);

    // Randomized traffic
    for (int it = 0; it < 3000; it++) begin
      if (it % 700 == 699) do_reset();
      v = ($urandom_range(99) < 75);
      s = ($urandom_range(99) < 3);
      r = $urandom_range(3);
      case (r)
        0:       ang = int'($urandom_range(360)) - 180;
        1:       ang = int'($urandom_range(800)) - 400;
        2:       ang = int'($signed(16'($urandom)));
        default: ang = m_prev + int'($urandom_range(4)) - 2;
      endcase
      drive(v, ang, s);
    end
    idle(4);

    check("queues_drained", longint'(chip_q.size() + word_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
